pwm_multi: RTL

Parametrised multi-channel PWM generator on the 32-bit rd/wr register bus used by the existing single-mode PWM block. Each channel has enable, edge- or centre-aligned mode, output polarity, period-end interrupt and shadowed PERIOD/DUTY registers, so live updates never produce a glitched cycle. It replaces the fixed 8-channel edge-only generator in peripheral designs needing more or fewer channels, wider counters or glitch-free duty updates.

---
 rtl/pwm_pkg.sv | 23 ++
 rtl/pwm_chan.sv | 105 ++++++++++
 rtl/pwm_multi.sv | 108 ++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// Shared register map, CTRL bit positions and counter direction type for the
// multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned OFF_CTRL    = 'h0;
  localparam int unsigned OFF_PERIOD  = 'h4;
  localparam int unsigned OFF_DUTY    = 'h8;
  localparam int unsigned CH_STRIDE   = 'hC;
  localparam int unsigned ADDR_STATUS = 'h60;
  localparam int unsigned ADDR_GCTRL  = 'h64;

  localparam int unsigned CTRL_EN     = 0;
  localparam int unsigned CTRL_CENTER = 1;
  localparam int unsigned CTRL_INV    = 2;
  localparam int unsigned CTRL_IE     = 3;
  localparam int unsigned CTRL_W      = 4;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: edge/centre counter, shadowed PERIOD/DUTY, compare,
// polarity and period-end pulse.
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_center,
  input  logic             i_inv,
  input  logic             i_sync,
  input  logic             i_per_wr,
  input  logic             i_duty_wr,
  input  logic [CNT_W-1:0] i_wdata,
  output logic [CNT_W-1:0] o_per_buf,
  output logic [CNT_W-1:0] o_duty_buf,
  output logic             o_pwm,
  output logic             o_pend
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_duty;
  logic [CNT_W-1:0] r_per_buf;
  logic [CNT_W-1:0] r_duty_buf;
  dir_e             r_dir;
  logic             r_pwm;

  logic [CNT_W-1:0] w_cnt_nxt;
  dir_e             w_dir_nxt;
  logic             w_pend;
  logic             w_active;

  always_comb begin
    w_active  = (r_per != '0) && (r_cnt < r_duty);
    w_pend    = 1'b0;
    w_cnt_nxt = r_cnt + ONE;
    w_dir_nxt = DIR_UP;
    if (r_per == '0) begin
      w_pend    = 1'b1;
      w_cnt_nxt = '0;
    end else if (!i_center) begin
      if (r_cnt >= r_per - ONE) begin
        w_pend    = 1'b1;
        w_cnt_nxt = '0;
      end
    end else if (r_dir == DIR_UP) begin
      // PERIOD=1 has an empty down leg, so its period end sits on cnt==0
      w_pend = (r_per == ONE) && (r_cnt == '0);
      if (r_cnt >= r_per) begin
        if (r_per == ONE) begin
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_per - ONE;
          w_dir_nxt = DIR_DOWN;
        end
      end
    end else begin
      if (r_cnt <= ONE) begin
        w_pend    = 1'b1;
        w_cnt_nxt = '0;
      end else begin
        w_cnt_nxt = r_cnt - ONE;
        w_dir_nxt = DIR_DOWN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_per      <= '0;
      r_duty     <= '0;
      r_per_buf  <= '0;
      r_duty_buf <= '0;
      r_dir      <= DIR_UP;
      r_pwm      <= 1'b0;
    end else begin
      if (i_per_wr)  r_per_buf  <= i_wdata;
      if (i_duty_wr) r_duty_buf <= i_wdata;
      if (!i_en || w_pend) begin
        r_per  <= r_per_buf;
        r_duty <= r_duty_buf;
      end
      if (!i_en || i_sync) begin
        r_cnt <= '0;
        r_dir <= DIR_UP;
      end else begin
        r_cnt <= w_cnt_nxt;
        r_dir <= w_dir_nxt;
      end
      r_pwm <= i_en ? (w_active ^ i_inv) : i_inv;
    end
  end

  assign o_per_buf  = r_per_buf;
  assign o_duty_buf = r_duty_buf;
  assign o_pwm      = r_pwm;
  assign o_pend     = i_en & w_pend;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: register decode, readback, CTRL storage,
// STATUS flags / irq, and CHANNELS instances of pwm_chan.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned CHANNELS = 8,
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rd,
  input  logic                wr,
  input  logic [ADDR_W-1:0]   adrs,
  input  logic [31:0]         din,
  output logic [31:0]         dout,
  output logic [CHANNELS-1:0] pwmo,
  output logic                irq
);

  logic [CTRL_W-1:0]   r_ctrl [CHANNELS];
  logic [CHANNELS-1:0] r_flags;
  logic                r_irq;
  logic [31:0]         r_dout;

  logic [ADDR_W-1:0]   w_addr;
  logic [CHANNELS-1:0] w_ctrl_sel;
  logic [CHANNELS-1:0] w_per_sel;
  logic [CHANNELS-1:0] w_duty_sel;
  logic [CHANNELS-1:0] w_pend;
  logic [CHANNELS-1:0] w_set;
  logic [CHANNELS-1:0] w_clr;
  logic [CNT_W-1:0]    w_per_buf  [CHANNELS];
  logic [CNT_W-1:0]    w_duty_buf [CHANNELS];
  logic                w_status_sel;
  logic                w_sync;
  logic [31:0]         w_rdata;

  assign w_addr = adrs & ~ADDR_W'(3);

  always_comb begin
    w_ctrl_sel   = '0;
    w_per_sel    = '0;
    w_duty_sel   = '0;
    w_rdata      = '0;
    w_status_sel = (w_addr == ADDR_W'(ADDR_STATUS));
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (w_addr == ADDR_W'(c * CH_STRIDE + OFF_CTRL)) begin
        w_ctrl_sel[c]         = 1'b1;
        w_rdata[CTRL_W-1:0]   = r_ctrl[c];
      end
      if (w_addr == ADDR_W'(c * CH_STRIDE + OFF_PERIOD)) begin
        w_per_sel[c]          = 1'b1;
        w_rdata[CNT_W-1:0]    = w_per_buf[c];
      end
      if (w_addr == ADDR_W'(c * CH_STRIDE + OFF_DUTY)) begin
        w_duty_sel[c]         = 1'b1;
        w_rdata[CNT_W-1:0]    = w_duty_buf[c];
      end
    end
    if (w_status_sel) w_rdata[CHANNELS-1:0] = r_flags;
  end

  assign w_sync = wr && (w_addr == ADDR_W'(ADDR_GCTRL)) && din[0];
  assign w_clr  = (wr && w_status_sel) ? din[CHANNELS-1:0] : '0;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    pwm_chan #(
      .CNT_W (CNT_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .i_en       (r_ctrl[g][CTRL_EN]),
      .i_center   (r_ctrl[g][CTRL_CENTER]),
      .i_inv      (r_ctrl[g][CTRL_INV]),
      .i_sync     (w_sync),
      .i_per_wr   (wr && w_per_sel[g]),
      .i_duty_wr  (wr && w_duty_sel[g]),
      .i_wdata    (din[CNT_W-1:0]),
      .o_per_buf  (w_per_buf[g]),
      .o_duty_buf (w_duty_buf[g]),
      .o_pwm      (pwmo[g]),
      .o_pend     (w_pend[g])
    );
    assign w_set[g] = w_pend[g] & r_ctrl[g][CTRL_IE];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned c = 0; c < CHANNELS; c++) r_ctrl[c] <= '0;
      r_flags <= '0;
      r_irq   <= 1'b0;
      r_dout  <= '0;
    end else begin
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (wr && w_ctrl_sel[c]) r_ctrl[c] <= din[CTRL_W-1:0];
      end
      // a new period end outranks a write-1-to-clear on the same edge
      r_flags <= (r_flags & ~w_clr) | w_set;
      r_irq   <= |r_flags;
      if (rd) r_dout <= w_rdata;
    end
  end

  assign dout = r_dout;
  assign irq  = r_irq;

endmodule
